// File: rtl/trig_ctrl_pkg.sv
// Shared definitions for the trigger-alignment sequencing controller:
// FSM state encoding and the default sizing constants.
package trig_ctrl_pkg;

    localparam int DEF_NUM_VFATS     = 24;
    localparam int DEF_WINDOW_BITS   = 12;
    localparam int DEF_SETTLE_CYCLES = 16;
    localparam int DEF_MAX_RETRIES   = 3;
    localparam int DEF_CNT_W         = 16;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_SETTLE  = 3'd1,
        ST_MEASURE = 3'd2,
        ST_EVAL    = 3'd3,
        ST_RESYNC  = 3'd4
    } state_t;

endpackage

// File: rtl/sat_counter.sv
// Up-counter with synchronous clear and optional saturation at all-ones.
// Clear has priority over increment.
module sat_counter #(
    parameter int WIDTH = 16
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             inc,
    input  logic             clr,
    input  logic             saturate,
    output logic [WIDTH-1:0] count
);

    // Counter register: reset/clear first, then increment unless pinned at max
    always_ff @(posedge clock) begin
        if (reset || clr) begin
            count <= '0;
        end else if (inc && !(saturate && (count == {WIDTH{1'b1}}))) begin
            count <= count + WIDTH'(1);
        end
    end

endmodule

// File: rtl/trig_alignment_ctrl.sv
// Round-robin scanner of the VFAT trigger units. Each unit gets a settle
// period, then an error-measurement window; failing units are resynced via
// a one-cycle frame-aligner reset and auto-masked after too many retries.
module trig_alignment_ctrl
    import trig_ctrl_pkg::*;
#(
    parameter int NUM_VFATS     = DEF_NUM_VFATS,
    parameter int WINDOW_BITS   = DEF_WINDOW_BITS,
    parameter int SETTLE_CYCLES = DEF_SETTLE_CYCLES,
    parameter int MAX_RETRIES   = DEF_MAX_RETRIES,
    parameter int CNT_W         = DEF_CNT_W
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic                 enable,
    input  logic [NUM_VFATS-1:0] alignment_err,
    input  logic [NUM_VFATS-1:0] sot_phase_err,
    input  logic [NUM_VFATS-1:0] mask_force,
    input  logic                 clear_cnt,
    input  logic [4:0]           rd_sel,
    output logic [NUM_VFATS-1:0] vfat_reset,
    output logic [NUM_VFATS-1:0] sbit_mask,
    output logic [NUM_VFATS-1:0] locked,
    output logic [CNT_W-1:0]     rd_err_cnt,
    output logic                 scan_done,
    output logic                 busy
);

    localparam int SETTLE_W = $clog2(SETTLE_CYCLES + 1);
    localparam int TIMER_W  = (WINDOW_BITS > SETTLE_W) ? WINDOW_BITS : SETTLE_W;
    localparam int RETRY_W  = $clog2(MAX_RETRIES + 1);

    localparam logic [TIMER_W-1:0] SETTLE_LAST = TIMER_W'(SETTLE_CYCLES - 1);
    localparam logic [TIMER_W-1:0] WINDOW_LAST = TIMER_W'((1 << WINDOW_BITS) - 1);
    localparam logic [4:0]         SEL_LAST    = 5'(NUM_VFATS - 1);
    localparam logic [RETRY_W:0]   RETRY_LIMIT = (RETRY_W + 1)'(MAX_RETRIES);

    state_t               state;
    state_t               state_next;
    logic [4:0]           sel;
    logic [4:0]           sel_next;
    logic [TIMER_W-1:0]   timer;
    logic                 timer_clr;
    logic                 win_flag;
    logic                 settle_done;
    logic                 advance;
    logic                 wrap;
    logic                 eval_pass;
    logic                 eval_fail;
    logic                 set_mask;
    logic                 start_resync;
    logic                 cur_err;
    logic                 cur_masked;
    logic                 retry_last;
    logic                 in_measure;
    logic [NUM_VFATS-1:0] auto_mask;
    logic [NUM_VFATS-1:0] err_inc;
    logic [NUM_VFATS-1:0] retry_inc;
    logic [NUM_VFATS-1:0] retry_clr;
    logic [CNT_W-1:0]     err_cnt   [NUM_VFATS];
    logic [RETRY_W-1:0]   retry_cnt [NUM_VFATS];

    assign sbit_mask  = auto_mask | mask_force;
    assign busy       = (state != ST_IDLE);
    assign in_measure = (state == ST_MEASURE);
    assign cur_err    = alignment_err[sel] | sot_phase_err[sel];
    assign cur_masked = sbit_mask[sel];
    assign retry_last = ({1'b0, retry_cnt[sel]} + (RETRY_W + 1)'(1)) >= RETRY_LIMIT;

    // Per-VFAT error and retry counters; a clean window resets the retry count
    for (genvar i = 0; i < NUM_VFATS; i++) begin : g_vfat
        assign err_inc[i]   = in_measure & (sel == 5'(i)) & (alignment_err[i] | sot_phase_err[i]);
        assign retry_inc[i] = eval_fail & (sel == 5'(i));
        assign retry_clr[i] = clear_cnt | (eval_pass & (sel == 5'(i)));

        sat_counter #(.WIDTH(CNT_W)) u_err_cnt (
            .clock    (clock),
            .reset    (reset),
            .inc      (err_inc[i]),
            .clr      (clear_cnt),
            .saturate (1'b1),
            .count    (err_cnt[i])
        );

        sat_counter #(.WIDTH(RETRY_W)) u_retry_cnt (
            .clock    (clock),
            .reset    (reset),
            .inc      (retry_inc[i]),
            .clr      (retry_clr[i]),
            .saturate (1'b1),
            .count    (retry_cnt[i])
        );
    end

    // Next-state logic; masked units are skipped from SETTLE in a single cycle
    always_comb begin
        state_next   = state;
        sel_next     = sel;
        timer_clr    = 1'b0;
        settle_done  = 1'b0;
        advance      = 1'b0;
        wrap         = 1'b0;
        eval_pass    = 1'b0;
        eval_fail    = 1'b0;
        set_mask     = 1'b0;
        start_resync = 1'b0;

        case (state)
            ST_IDLE: begin
                timer_clr = 1'b1;
                if (enable) begin
                    sel_next   = '0;
                    state_next = ST_SETTLE;
                end
            end
            ST_SETTLE: begin
                if (cur_masked) begin
                    advance = 1'b1;
                end else if (timer == SETTLE_LAST) begin
                    settle_done = 1'b1;
                    timer_clr   = 1'b1;
                    state_next  = ST_MEASURE;
                end
            end
            ST_MEASURE: begin
                if (timer == WINDOW_LAST) begin
                    timer_clr  = 1'b1;
                    state_next = ST_EVAL;
                end
            end
            ST_EVAL: begin
                timer_clr = 1'b1;
                if (!win_flag) begin
                    eval_pass = 1'b1;
                    advance   = 1'b1;
                end else begin
                    eval_fail = 1'b1;
                    if (retry_last) begin
                        set_mask = 1'b1;
                        advance  = 1'b1;
                    end else begin
                        start_resync = 1'b1;
                        state_next   = ST_RESYNC;
                    end
                end
            end
            ST_RESYNC: begin
                timer_clr  = 1'b1;
                state_next = enable ? ST_SETTLE : ST_IDLE;
            end
            default: begin
                timer_clr  = 1'b1;
                state_next = ST_IDLE;
            end
        endcase

        if (advance) begin
            timer_clr  = 1'b1;
            state_next = enable ? ST_SETTLE : ST_IDLE;
            if (sel == SEL_LAST) begin
                sel_next = '0;
                wrap     = 1'b1;
            end else begin
                sel_next = sel + 5'd1;
            end
        end
    end

    // State, unit index and shared settle/window timer
    always_ff @(posedge clock) begin
        if (reset) begin
            state <= ST_IDLE;
            sel   <= '0;
            timer <= '0;
        end else begin
            state <= state_next;
            sel   <= sel_next;
            timer <= timer_clr ? '0 : timer + TIMER_W'(1);
        end
    end

    // Window error flag: cleared entering MEASURE, sticky on any errored cycle
    always_ff @(posedge clock) begin
        if (reset || settle_done) begin
            win_flag <= 1'b0;
        end else if (in_measure && cur_err) begin
            win_flag <= 1'b1;
        end
    end

    // Lock status, auto-mask, aligner reset pulse and end-of-pass strobe
    always_ff @(posedge clock) begin
        if (reset) begin
            locked     <= '0;
            auto_mask  <= '0;
            vfat_reset <= '0;
            scan_done  <= 1'b0;
        end else begin
            if (eval_pass) begin
                locked[sel] <= 1'b1;
            end else if (eval_fail) begin
                locked[sel] <= 1'b0;
            end
            if (clear_cnt) begin
                auto_mask <= '0;
            end else if (set_mask) begin
                auto_mask[sel] <= 1'b1;
            end
            vfat_reset <= start_resync ? ({{(NUM_VFATS-1){1'b0}}, 1'b1} << sel) : '0;
            scan_done  <= wrap;
        end
    end

    // Registered counter readback; out-of-range selects read as zero
    always_ff @(posedge clock) begin
        if (reset) begin
            rd_err_cnt <= '0;
        end else if ({1'b0, rd_sel} < 6'(NUM_VFATS)) begin
            rd_err_cnt <= err_cnt[rd_sel];
        end else begin
            rd_err_cnt <= '0;
        end
    end

endmodule

// File: tb/tb_trig_alignment_ctrl.sv
// Directed bench for trig_alignment_ctrl with a short window (16 cycles),
// 2 settle cycles, 3 retries and 4-bit counters: 19 cycles per VFAT.
module tb_trig_alignment_ctrl;

    localparam int NV = 24;

    logic          clock = 1'b0;
    logic          reset;
    logic          enable;
    logic [NV-1:0] alignment_err;
    logic [NV-1:0] sot_phase_err;
    logic [NV-1:0] mask_force;
    logic          clear_cnt;
    logic [4:0]    rd_sel;
    logic [NV-1:0] vfat_reset;
    logic [NV-1:0] sbit_mask;
    logic [NV-1:0] locked;
    logic [3:0]    rd_err_cnt;
    logic          scan_done;
    logic          busy;

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;
    int base     = 0;
    int pulse_cnt [NV];
    int pulse_total = 0;

    trig_alignment_ctrl #(
        .NUM_VFATS     (NV),
        .WINDOW_BITS   (4),
        .SETTLE_CYCLES (2),
        .MAX_RETRIES   (3),
        .CNT_W         (4)
    ) dut (
        .clock         (clock),
        .reset         (reset),
        .enable        (enable),
        .alignment_err (alignment_err),
        .sot_phase_err (sot_phase_err),
        .mask_force    (mask_force),
        .clear_cnt     (clear_cnt),
        .rd_sel        (rd_sel),
        .vfat_reset    (vfat_reset),
        .sbit_mask     (sbit_mask),
        .locked        (locked),
        .rd_err_cnt    (rd_err_cnt),
        .scan_done     (scan_done),
        .busy          (busy)
    );

    always #5 clock = ~clock;

    // cycle counter used to time directed stimulus relative to 'base'
    always @(posedge clock) cyc <= cyc + 1;

    // count every vfat_reset pulse per unit
    initial for (int i = 0; i < NV; i++) pulse_cnt[i] = 0;
    always @(negedge clock) begin
        for (int i = 0; i < NV; i++) begin
            if (vfat_reset[i] === 1'b1) begin
                pulse_cnt[i] <= pulse_cnt[i] + 1;
                pulse_total  <= pulse_total + 1;
            end
        end
    end

    initial begin
        #1000000;
        $display("[TB] FAIL watchdog: simulation time limit reached, got timeout expected finish");
        $fatal(1, "[TB] watchdog");
    end

    task automatic wait_until(input int k);
        while ((cyc - base) < k) @(negedge clock);
    endtask

    task automatic wait_scan_done(input int limit, output int at);
        at = -1;
        while ((cyc - base) < limit) begin
            @(negedge clock);
            if (scan_done === 1'b1) begin
                at = cyc - base;
                break;
            end
        end
    endtask

    task automatic do_reset();
        @(negedge clock);
        reset = 1'b1; enable = 1'b0; alignment_err = '0; sot_phase_err = '0;
        mask_force = '0; clear_cnt = 1'b0; rd_sel = '0;
        repeat (2) @(negedge clock);
        reset = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1; enable = 1'b1; alignment_err = '0; sot_phase_err = '0;
        mask_force = 24'h0000A5; clear_cnt = 1'b0; rd_sel = 5'd3;
        repeat (3) @(negedge clock);
        checks++; if (busy !== 1'b0) begin failures++; $display("[TB] FAIL reset_busy: got %b expected 0", busy); end
        checks++; if (locked !== 24'h0) begin failures++; $display("[TB] FAIL reset_locked: got %h expected 000000", locked); end
        checks++; if (vfat_reset !== 24'h0) begin failures++; $display("[TB] FAIL reset_vfat_reset: got %h expected 000000", vfat_reset); end
        checks++; if (scan_done !== 1'b0) begin failures++; $display("[TB] FAIL reset_scan_done: got %b expected 0", scan_done); end
        checks++; if (rd_err_cnt !== 4'd0) begin failures++; $display("[TB] FAIL reset_rd_err_cnt: got %0d expected 0", rd_err_cnt); end
        checks++; if (sbit_mask !== 24'h0000A5) begin failures++; $display("[TB] FAIL reset_sbit_mask: got %h expected 0000a5", sbit_mask); end
    endtask

    task automatic test_clean_lock();
        int at;
        int p0;
        do_reset();
        p0 = pulse_total;
        enable = 1'b1; base = cyc;
        checks++; if (busy !== 1'b0) begin failures++; $display("[TB] FAIL lock_busy_before: got %b expected 0", busy); end
        wait_until(1);
        checks++; if (busy !== 1'b1) begin failures++; $display("[TB] FAIL lock_busy_rise: got %b expected 1", busy); end
        wait_scan_done(2000, at);
        checks++; if (at !== 457) begin failures++; $display("[TB] FAIL lock_scan_time: got %0d expected 457", at); end
        checks++; if (locked !== 24'hFFFFFF) begin failures++; $display("[TB] FAIL lock_locked: got %h expected ffffff", locked); end
        checks++; if (pulse_total - p0 !== 0) begin failures++; $display("[TB] FAIL lock_no_resets: got %0d expected 0", pulse_total - p0); end
        foreach (dut.locked[k]) begin
            if (k % 11 == 0) begin
                rd_sel = 5'(k);
                @(negedge clock);
                checks++; if (rd_err_cnt !== 4'd0) begin failures++; $display("[TB] FAIL lock_cnt_%0d: got %0d expected 0", k, rd_err_cnt); end
            end
        end
    endtask

    task automatic test_single_retry();
        int at;
        int p5;
        int pt;
        do_reset();
        p5 = pulse_cnt[5]; pt = pulse_total;
        enable = 1'b1; base = cyc;
        wait_until(100); alignment_err[5] = 1'b1;
        wait_until(103); alignment_err[5] = 1'b0;
        wait_until(114);
        checks++; if (vfat_reset !== 24'h0) begin failures++; $display("[TB] FAIL retry_pulse_early: got %h expected 000000", vfat_reset); end
        wait_until(115);
        checks++; if (vfat_reset !== 24'h000020) begin failures++; $display("[TB] FAIL retry_pulse: got %h expected 000020", vfat_reset); end
        wait_scan_done(2000, at);
        checks++; if (at !== 477) begin failures++; $display("[TB] FAIL retry_scan_time: got %0d expected 477", at); end
        checks++; if (pulse_cnt[5] - p5 !== 1) begin failures++; $display("[TB] FAIL retry_pulse_count5: got %0d expected 1", pulse_cnt[5] - p5); end
        checks++; if (pulse_total - pt !== 1) begin failures++; $display("[TB] FAIL retry_pulse_total: got %0d expected 1", pulse_total - pt); end
        checks++; if (locked !== 24'hFFFFFF) begin failures++; $display("[TB] FAIL retry_locked: got %h expected ffffff", locked); end
        rd_sel = 5'd5;
        @(negedge clock);
        checks++; if (rd_err_cnt !== 4'd3) begin failures++; $display("[TB] FAIL retry_cnt5: got %0d expected 3", rd_err_cnt); end
        rd_sel = 5'd4;
        @(negedge clock);
        checks++; if (rd_err_cnt !== 4'd0) begin failures++; $display("[TB] FAIL retry_cnt4: got %0d expected 0", rd_err_cnt); end
    endtask

    task automatic test_auto_mask();
        int at;
        int p9;
        do_reset();
        p9 = pulse_cnt[9];
        enable = 1'b1; base = cyc; rd_sel = 5'd9;
        sot_phase_err[9] = 1'b1;
        wait_scan_done(2000, at);
        checks++; if (at !== 497) begin failures++; $display("[TB] FAIL mask_scan_time: got %0d expected 497", at); end
        checks++; if (pulse_cnt[9] - p9 !== 2) begin failures++; $display("[TB] FAIL mask_pulses9: got %0d expected 2", pulse_cnt[9] - p9); end
        checks++; if (sbit_mask !== 24'h000200) begin failures++; $display("[TB] FAIL mask_sbit_mask: got %h expected 000200", sbit_mask); end
        checks++; if (locked !== 24'hFFFDFF) begin failures++; $display("[TB] FAIL mask_locked: got %h expected fffdff", locked); end
        checks++; if (rd_err_cnt !== 4'd15) begin failures++; $display("[TB] FAIL mask_cnt9_saturated: got %0d expected 15", rd_err_cnt); end
        wait_scan_done(2000, at);
        checks++; if (at !== 935) begin failures++; $display("[TB] FAIL mask_skip_scan_time: got %0d expected 935", at); end
        checks++; if (pulse_cnt[9] - p9 !== 2) begin failures++; $display("[TB] FAIL mask_no_more_pulses: got %0d expected 2", pulse_cnt[9] - p9); end
        clear_cnt = 1'b1;
        @(negedge clock);
        clear_cnt = 1'b0;
        checks++; if (sbit_mask !== 24'h0) begin failures++; $display("[TB] FAIL mask_clear_sbit: got %h expected 000000", sbit_mask); end
        @(negedge clock);
        checks++; if (rd_err_cnt !== 4'd0) begin failures++; $display("[TB] FAIL mask_clear_cnt9: got %0d expected 0", rd_err_cnt); end
        sot_phase_err = '0;
    endtask

    task automatic test_sat_clear();
        do_reset();
        enable = 1'b1; base = cyc; rd_sel = 5'd0;
        alignment_err[0] = 1'b1;
        wait_until(18);
        checks++; if (rd_err_cnt !== 4'd14) begin failures++; $display("[TB] FAIL sat_cnt_14: got %0d expected 14", rd_err_cnt); end
        wait_until(20);
        checks++; if (vfat_reset !== 24'h000001) begin failures++; $display("[TB] FAIL sat_pulse1: got %h expected 000001", vfat_reset); end
        wait_until(25);
        checks++; if (rd_err_cnt !== 4'd15) begin failures++; $display("[TB] FAIL sat_hold_15: got %0d expected 15", rd_err_cnt); end
        wait_until(29); clear_cnt = 1'b1;
        wait_until(30); clear_cnt = 1'b0;
        wait_until(31);
        checks++; if (rd_err_cnt !== 4'd0) begin failures++; $display("[TB] FAIL sat_clear_wins: got %0d expected 0", rd_err_cnt); end
        wait_until(32);
        checks++; if (rd_err_cnt !== 4'd1) begin failures++; $display("[TB] FAIL sat_recount: got %0d expected 1", rd_err_cnt); end
        wait_until(60);
        checks++; if (vfat_reset !== 24'h000001) begin failures++; $display("[TB] FAIL sat_retry_cleared: got %h expected 000001", vfat_reset); end
        wait_until(79); clear_cnt = 1'b1;
        wait_until(80); clear_cnt = 1'b0;
        checks++; if (sbit_mask !== 24'h0) begin failures++; $display("[TB] FAIL sat_mask_clear_wins: got %h expected 000000", sbit_mask); end
        checks++; if (vfat_reset !== 24'h0) begin failures++; $display("[TB] FAIL sat_mask_eval_advanced: got %h expected 000000", vfat_reset); end
        wait_until(81);
        checks++; if (rd_err_cnt !== 4'd0) begin failures++; $display("[TB] FAIL sat_final_cnt: got %0d expected 0", rd_err_cnt); end
        alignment_err = '0;
    endtask

    task automatic test_reset_mid_window();
        do_reset();
        enable = 1'b1; base = cyc; rd_sel = 5'd12;
        wait_until(233); alignment_err[12] = 1'b1;
        wait_until(236); alignment_err[12] = 1'b0;
        wait_until(238);
        checks++; if (locked !== 24'h000FFF) begin failures++; $display("[TB] FAIL mid_locked_before: got %h expected 000fff", locked); end
        checks++; if (rd_err_cnt !== 4'd3) begin failures++; $display("[TB] FAIL mid_cnt_before: got %0d expected 3", rd_err_cnt); end
        reset = 1'b1;
        wait_until(239);
        checks++; if (busy !== 1'b0) begin failures++; $display("[TB] FAIL mid_busy: got %b expected 0", busy); end
        checks++; if (locked !== 24'h0) begin failures++; $display("[TB] FAIL mid_locked: got %h expected 000000", locked); end
        checks++; if (vfat_reset !== 24'h0) begin failures++; $display("[TB] FAIL mid_vfat_reset: got %h expected 000000", vfat_reset); end
        checks++; if (rd_err_cnt !== 4'd0) begin failures++; $display("[TB] FAIL mid_rd_err_cnt: got %0d expected 0", rd_err_cnt); end
        reset = 1'b0; base = cyc;
        wait_until(1);
        checks++; if (busy !== 1'b1) begin failures++; $display("[TB] FAIL mid_restart_busy: got %b expected 1", busy); end
        checks++; if (rd_err_cnt !== 4'd0) begin failures++; $display("[TB] FAIL mid_cnt_cleared: got %0d expected 0", rd_err_cnt); end
        wait_until(19);
        checks++; if (locked !== 24'h0) begin failures++; $display("[TB] FAIL mid_restart_early: got %h expected 000000", locked); end
        wait_until(20);
        checks++; if (locked !== 24'h000001) begin failures++; $display("[TB] FAIL mid_restart_vfat0: got %h expected 000001", locked); end
    endtask

    task automatic test_force_mask_readback();
        int at;
        do_reset();
        mask_force = 24'h00000F;
        #1;
        checks++; if (sbit_mask !== 24'h00000F) begin failures++; $display("[TB] FAIL force_sbit_mask: got %h expected 00000f", sbit_mask); end
        enable = 1'b1; base = cyc;
        wait_until(10); alignment_err[4] = 1'b1;
        wait_until(12); alignment_err[4] = 1'b0;
        wait_until(23);
        checks++; if (vfat_reset !== 24'h0) begin failures++; $display("[TB] FAIL force_pulse_early: got %h expected 000000", vfat_reset); end
        wait_until(24);
        checks++; if (vfat_reset !== 24'h000010) begin failures++; $display("[TB] FAIL force_first_unit4: got %h expected 000010", vfat_reset); end
        wait_scan_done(2000, at);
        checks++; if (at !== 405) begin failures++; $display("[TB] FAIL force_scan_time: got %0d expected 405", at); end
        checks++; if (locked !== 24'hFFFFF0) begin failures++; $display("[TB] FAIL force_locked: got %h expected fffff0", locked); end
        rd_sel = 5'd4;
        @(negedge clock);
        checks++; if (rd_err_cnt !== 4'd2) begin failures++; $display("[TB] FAIL force_cnt4: got %0d expected 2", rd_err_cnt); end
        rd_sel = 5'd30;
        @(negedge clock);
        checks++; if (rd_err_cnt !== 4'd0) begin failures++; $display("[TB] FAIL force_rd30: got %0d expected 0", rd_err_cnt); end
        rd_sel = 5'd4;
        @(negedge clock);
        rd_sel = 5'd24;
        @(negedge clock);
        checks++; if (rd_err_cnt !== 4'd0) begin failures++; $display("[TB] FAIL force_rd24: got %0d expected 0", rd_err_cnt); end
    endtask

    initial begin
        test_reset();
        test_clean_lock();
        test_single_retry();
        test_auto_mask();
        test_sat_clear();
        test_reset_mid_window();
        test_force_mask_readback();
        $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
        $finish;
    end

endmodule

// File: doc/trig_alignment_ctrl.md
# trig_alignment_ctrl

Sequencing controller for the trigger-alignment datapath. Scans the 24 VFAT trigger units round-robin, checking each for frame-alignment and start-of-frame phase errors over a fixed window. A unit that fails repeatedly is resynchronised by pulsing its frame-aligner reset, and is masked after a retry limit. The block drives the per-VFAT `sbit_mask` and per-VFAT reset of the alignment datapath, and reports per-VFAT lock status and error counts to slow control.

## Interface
- `NUM_VFATS`, 24, number of trigger units scanned
- `WINDOW_BITS`, 12, measurement window = 2^WINDOW_BITS cycles
- `SETTLE_CYCLES`, 16, cycles ignored after selecting or resetting a unit
- `MAX_RETRIES`, 3, consecutive failed windows before a unit is masked
- `CNT_W`, 16, width of the per-VFAT saturating error counter

Ports:
- `clock`  in  1  40 MHz logic clock
- `reset`  in  1  synchronous, active-high
- `enable`  in  1  run scanning; when low, FSM parks in IDLE
- `alignment_err`  in  NUM_VFATS  per-VFAT frame-alignment error, level
- `sot_phase_err`  in  NUM_VFATS  per-VFAT SOF phase error, level
- `mask_force`  in  NUM_VFATS  slow-control forced mask, ORed into `sbit_mask`
- `clear_cnt`  in  1  single-cycle pulse: zero all error counters and retry counts, clear auto-mask
- `rd_sel`  in  5  VFAT index for counter readback
- `vfat_reset`  out  NUM_VFATS  one-hot, single-cycle reset pulse to a frame aligner
- `sbit_mask`  out  NUM_VFATS  `auto_mask | mask_force`
- `locked`  out  NUM_VFATS  last completed window for the VFAT had zero errors
- `rd_err_cnt`  out  CNT_W  error counter of VFAT `rd_sel`, registered; 0 if `rd_sel` ≥ NUM_VFATS
- `scan_done`  out  1  one-cycle pulse after the last VFAT's EVAL
- `busy`  out  1  FSM not in IDLE

## Operation
- States are IDLE, SETTLE, MEASURE, EVAL and RESYNC. The index `sel` runs 0..NUM_VFATS-1.
- **IDLE:** if `enable`, set `sel`=0 and go to SETTLE.
- **SETTLE:** count SETTLE_CYCLES, then clear the window flag and go to MEASURE.
- **MEASURE:** for 2^WINDOW_BITS cycles, set the window flag if `alignment_err[sel] | sot_phase_err[sel]`. On every errored cycle, increment `err_cnt[sel]`, saturating at all-ones. Then go to EVAL.
- **EVAL, flag clear:**
  - `locked[sel]`←1 and `retry[sel]`←0.
  - Advance to the next VFAT.
- **EVAL, flag set:**
  - `locked[sel]`←0 and `retry[sel]`++.
  - If `retry[sel]` reaches MAX_RETRIES, set `auto_mask[sel]` and advance.
  - Otherwise go to RESYNC.
- **RESYNC:** assert `vfat_reset[sel]` for exactly one cycle, then go to SETTLE with the same `sel`.
- **Advance:** `sel`++. After NUM_VFATS-1, wrap to 0, pulse `scan_done`, and go to IDLE if `enable`=0, else SETTLE.
- **Masked VFATs:** a VFAT already masked (`auto_mask` or `mask_force`) is skipped during advance without measuring. Skipping costs one cycle per VFAT.
- **All masked:** `scan_done` still pulses once per pass, and no VFAT is measured.
- **`enable` deasserted mid-scan:** the current window completes through EVAL/RESYNC. The FSM then goes to IDLE instead of SETTLE, and `sel` is preserved only until the next IDLE exit, which restarts at 0.
- **`clear_cnt`:**
  - Clears all counters, `retry` and `auto_mask` in the cycle after the pulse.
  - Does not change FSM state.
  - If it coincides with an increment of the same counter, the clear wins.
  - If it coincides with EVAL setting a mask, the clear wins.
- **`reset`:** every output and register returns to its reset value on the next edge, from any state including mid-window. Reset values:
  - `vfat_reset`=0, `sbit_mask`=`mask_force` (`auto_mask`=0), `locked`=0
  - counters=0, `rd_err_cnt`=0, `scan_done`=0, `busy`=0, FSM=IDLE

## Timing
- `sbit_mask` is combinational from registered `auto_mask` and the input `mask_force`.
- `vfat_reset` is registered. It is high in the single cycle after EVAL decides RESYNC.
- `rd_err_cnt` has a latency of 1 cycle from `rd_sel`.
- Per-VFAT pass time is SETTLE_CYCLES + 2^WINDOW_BITS + 1 cycles. A retry adds 1 + SETTLE_CYCLES + 2^WINDOW_BITS + 1.
- `busy` rises 1 cycle after `enable` is seen in IDLE.

## Structure
- Shared package `trig_ctrl_pkg` holds:
  - the FSM state enumeration
  - the default constants (24 VFATs, window bits, settle cycles, retry limit)
- Counter and retry storage are indexed arrays. The increment/saturate/clear logic for these arrays should be the single sub-module `sat_counter` (width CNT_W, with inc/clr/saturate ports), instantiated per VFAT.
- No other sub-modules.

## Test plan
- **Clean lock:** `enable`=1, all errors 0, WINDOW_BITS=4, SETTLE=2 → `locked`=all ones after the first `scan_done`; `vfat_reset` never asserted; counters 0.
- **Single retry:** error on VFAT 5 held for 3 cycles in the first window only → one `vfat_reset[5]` pulse, then `locked[5]`=1, `rd_err_cnt` at `rd_sel`=5 reads 3.
- **Auto-mask:** `sot_phase_err[9]` held high permanently, MAX_RETRIES=3 → exactly 2 `vfat_reset[9]` pulses, then `sbit_mask[9]`=1. Later passes skip VFAT 9 with no further resets.
- **Saturation and clear:** CNT_W=4 with a constant error → counter holds 15. A `clear_cnt` coincident with an increment → next read is 0 and `auto_mask` is cleared.
- **Reset mid-window:** assert `reset` during MEASURE of VFAT 12 → next cycle `busy`=0, `locked`=0, `vfat_reset`=0, counters 0; with `enable` still high, the scan restarts at VFAT 0.
- **Forced mask and readback:** `mask_force`=0x00000F → `sbit_mask` low nibble set immediately and VFATs 0-3 skipped. `rd_sel`=30 → `rd_err_cnt`=0.
